// File: rtl/ch2_38_decoder.sv
// ch2_38_decoder
//
// Registered 3-to-8 line decoder. A binary select is turned into a one-hot
// line with exactly one clock of latency. There is no combinational path from
// SEL to O. This is a leaf block used to drive the select and enable lines of
// downstream muxes.
//
// Parameters
//   SEL_W  select width (legal 1..5). O is 2**SEL_W bits wide.
//
// Ports
//   CLK  in   1         rising-edge clock, the only clock
//   RST  in   1         asynchronous, active-high reset
//   EN   in   1         decode enable, sampled on CLK rise
//   SEL  in   SEL_W     binary select
//   O    out  2**SEL_W  registered one-hot decode
//   VLD  out  1         high while O holds a decode of an enabled SEL
//
// Configuration macro
//   DECODER_ACTIVE_LOW_EN
//     Undefined (default): O is active-high. The idle and reset value is all zeros.
//     Defined: every O bit is inverted. The selected line is 0 and all other
//     lines are 1. The idle and reset value is all ones. VLD stays active-high
//     in both builds.

module ch2_38_decoder #(
    parameter int SEL_W = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [SEL_W-1:0]      SEL,
    output logic [(1<<SEL_W)-1:0] O,
    output logic                  VLD
);

    localparam int OW = 1 << SEL_W;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OW-1:0] INACTIVE = '1;
`else
    localparam logic [OW-1:0] INACTIVE = '0;
`endif

    logic [OW-1:0] o_q, o_d;
    logic          vld_q, vld_d;
    logic [OW-1:0] oneHot;

    // Next-state decode. The one-hot pattern is XORed with the inactive
    // value so that the active-low build flips every bit without needing a
    // second decode path. When the select is unknown in simulation, the
    // output is forced idle so an X never reaches the downstream enables.
    always_comb begin
        oneHot      = '0;
        oneHot[SEL] = 1'b1;
        o_d         = INACTIVE;
        vld_d       = 1'b0;
        if (EN) begin
            o_d   = oneHot ^ INACTIVE;
            vld_d = 1'b1;
        end
`ifndef SYNTHESIS
        if (EN && $isunknown(SEL)) begin
            o_d   = INACTIVE;
            vld_d = 1'b0;
        end
`endif
    end

    // Output registers. Reset clears them at once without waiting for a clock
    // edge. Any sample that was in flight when reset arrived is lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_q   <= INACTIVE;
            vld_q <= 1'b0;
        end else begin
            o_q   <= o_d;
            vld_q <= vld_d;
        end
    end

    assign O   = o_q;
    assign VLD = vld_q;

`ifndef SYNTHESIS
    // Output invariants. When VLD is high, exactly one line is active.
    // When VLD is low, no line is active.
    validOneHot: assert property (@(posedge CLK) disable iff (RST)
        VLD |-> $onehot(O ^ INACTIVE));
    idleInactive: assert property (@(posedge CLK) disable iff (RST)
        !VLD |-> (O == INACTIVE));
`endif

endmodule

// File: tb/tb_ch2_38_decoder.sv
// Testbench for ch2_38_decoder (default 3-bit select)
//
// The bench runs a table of {EN, SEL, expected O, expected VLD} vectors. Each
// vector is applied for one cycle and checked one cycle later. Hand-written
// sequences cover reset: asynchronous clear in the middle of a cycle, loss of
// the in-flight sample, and a normal decode on the first edge after reset is
// released. Expected O values are written as active-high one-hot constants.
// In the active-low build they are XORed with 8'hFF.

module tb_ch2_38_decoder;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] INACT = 8'hFF;
`else
    localparam logic [7:0] INACT = 8'h00;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] sel;
    logic [7:0] o;
    logic       vld;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       en;
        logic [2:0] sel;
        logic [7:0] expO;
        logic       expVld;
    } vec_t;

    vec_t vecs[15];

    ch2_38_decoder #(.SEL_W(3)) dut (
        .CLK (clk),
        .RST (rst),
        .EN  (en),
        .SEL (sel),
        .O   (o),
        .VLD (vld)
    );

    // Free-running clock with a 10-unit period. Rising edges occur at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic enV, input logic [2:0] selV);
        en  = enV;
        sel = selV;
    endtask

    // expO is given active-high. It is converted here to the polarity of the build.
    task automatic checkOutput(input string name, input logic [7:0] expO, input logic expVld);
        logic [7:0] want;
        want = expO ^ INACT;
        compared++;
        if (o !== want || vld !== expVld) begin
            mismatched++;
            $display("[TB] FAIL %s: got O=%02h VLD=%0b, want O=%02h VLD=%0b",
                     name, o, vld, want, expVld);
        end
    endtask

    initial begin
        // SEL sweep: each code appears one cycle after it is presented.
        vecs[0]  = '{1'b1, 3'b000, 8'h01, 1'b1};
        vecs[1]  = '{1'b1, 3'b001, 8'h02, 1'b1};
        vecs[2]  = '{1'b1, 3'b010, 8'h04, 1'b1};
        vecs[3]  = '{1'b1, 3'b011, 8'h08, 1'b1};
        vecs[4]  = '{1'b1, 3'b100, 8'h10, 1'b1};
        vecs[5]  = '{1'b1, 3'b101, 8'h20, 1'b1};
        vecs[6]  = '{1'b1, 3'b110, 8'h40, 1'b1};
        vecs[7]  = '{1'b1, 3'b111, 8'h80, 1'b1};
        // Enable drop for one cycle with SEL=101, then recovery.
        vecs[8]  = '{1'b1, 3'b101, 8'h20, 1'b1};
        vecs[9]  = '{1'b0, 3'b101, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 3'b101, 8'h20, 1'b1};
        // SEL=011 held for four cycles: O must stay constant.
        vecs[11] = '{1'b1, 3'b011, 8'h08, 1'b1};
        vecs[12] = '{1'b1, 3'b011, 8'h08, 1'b1};
        vecs[13] = '{1'b1, 3'b011, 8'h08, 1'b1};
        vecs[14] = '{1'b1, 3'b011, 8'h08, 1'b1};

        rst = 1'b1;
        applyStimulus(1'b0, 3'b000);
        #3;
        checkOutput("reset_state", 8'h00, 1'b0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].en, vecs[i].sel);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].expO, vecs[i].expVld);
            @(negedge clk);
        end

        // Top code decoded, then reset pulsed in the middle of the cycle.
        applyStimulus(1'b1, 3'b111);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_80", 8'h80, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_clear", 8'h00, 1'b0);

        // A sample presented while reset is held must be dropped.
        applyStimulus(1'b1, 3'b010);
        @(posedge clk);
        #1;
        checkOutput("inflight_discard", 8'h00, 1'b0);

        // The first edge after reset release decodes normally.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_after_reset", 8'h04, 1'b1);

        // A disabled cycle after active use returns O to idle.
        @(negedge clk);
        applyStimulus(1'b0, 3'b111);
        @(posedge clk);
        #1;
        checkOutput("disable_idle", 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
